// File: rtl/div_controller.sv
// Sequential non-restoring divider with start/done handshake.
// Signed operands are divided as magnitudes; signs are restored in one FIX
// cycle. A zero divisor bypasses the iteration and flags div_by_zero.
module div_controller #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             clear_n,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] QUOTIENT,
   output logic [WIDTH-1:0] REMAINDER
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state_reg, state_next;
   logic [CW-1:0]    count_reg;
   // One extra bit so a magnitude of 2^(WIDTH-1) still leaves room for the sign.
   logic [WIDTH:0]   r_reg;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] m_reg;
   logic             neg_q_reg;
   logic             neg_r_reg;
   logic [WIDTH-1:0] quotient_reg;
   logic [WIDTH-1:0] remainder_reg;
   logic             dbz_reg;

   logic             b_zero;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH:0]   shift_r;
   logic [WIDTH:0]   step_r;
   logic [WIDTH:0]   fix_r;
   logic             last_iter;

   // Operand conditioning and the combinational non-restoring step.
   always_comb begin
      b_zero    = (B == '0);
      a_mag     = (signed_op && A[WIDTH-1]) ? -A : A;
      b_mag     = (signed_op && B[WIDTH-1]) ? -B : B;
      // The top bit of R drops out of the shift, but the result of the add or
      // subtract always fits WIDTH+1 bits, so modular arithmetic is exact.
      shift_r   = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
      step_r    = r_reg[WIDTH] ? (shift_r + {1'b0, m_reg})
                               : (shift_r - {1'b0, m_reg});
      fix_r     = r_reg[WIDTH] ? (r_reg + {1'b0, m_reg}) : r_reg;
      last_iter = (count_reg == CW'(WIDTH - 1));
   end

   // State register.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic: IDLE -> ITER (WIDTH steps) -> FIX -> DONE -> IDLE.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (start) state_next = b_zero ? DONE : ITER;
         ITER: if (last_iter) state_next = FIX;
         FIX:  state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Handshake outputs decoded from state; results come straight from registers.
   always_comb begin
      busy        = (state_reg != IDLE);
      done        = (state_reg == DONE);
      div_by_zero = dbz_reg;
      QUOTIENT    = quotient_reg;
      REMAINDER   = remainder_reg;
   end

   // Datapath: capture on start, iterate, then sign-correct into the result registers.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         count_reg     <= '0;
         r_reg         <= '0;
         q_reg         <= '0;
         m_reg         <= '0;
         neg_q_reg     <= 1'b0;
         neg_r_reg     <= 1'b0;
         quotient_reg  <= '0;
         remainder_reg <= '0;
         dbz_reg       <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  if (b_zero) begin
                     quotient_reg  <= '0;
                     remainder_reg <= '0;
                     dbz_reg       <= 1'b1;
                  end else begin
                     m_reg     <= b_mag;
                     q_reg     <= a_mag;
                     r_reg     <= '0;
                     neg_q_reg <= signed_op & (A[WIDTH-1] ^ B[WIDTH-1]);
                     neg_r_reg <= signed_op & A[WIDTH-1];
                     count_reg <= '0;
                     dbz_reg   <= 1'b0;
                  end
               end
            end
            ITER: begin
               r_reg     <= step_r;
               q_reg     <= {q_reg[WIDTH-2:0], ~step_r[WIDTH]};
               count_reg <= count_reg + 1'b1;
            end
            FIX: begin
               r_reg         <= fix_r;
               quotient_reg  <= neg_q_reg ? -q_reg : q_reg;
               remainder_reg <= neg_r_reg ? -fix_r[WIDTH-1:0] : fix_r[WIDTH-1:0];
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_controller.sv
// Scoreboard bench for div_controller: each accepted start pushes the
// reference result and its expected done cycle; the monitor pops on done.
module tb_div_controller;

   localparam int WIDTH = 32;

   logic             clock = 1'b0;
   logic             clear_n = 1'b0;
   logic             start = 1'b0;
   logic             signed_op = 1'b0;
   logic [WIDTH-1:0] a_in = '0;
   logic [WIDTH-1:0] b_in = '0;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int ops = 0;

   typedef struct {
      logic [WIDTH-1:0] q;
      logic [WIDTH-1:0] r;
      logic             dbz;
      int               cyc;
   } exp_t;

   exp_t sb[$];

   div_controller #(.WIDTH(WIDTH)) dut (
      .clock       (clock),
      .clear_n     (clear_n),
      .start       (start),
      .signed_op   (signed_op),
      .A           (a_in),
      .B           (b_in),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .QUOTIENT    (quotient),
      .REMAINDER   (remainder)
   );

   always #5 clock = ~clock;

   // Edge counter used to check done latency.
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: 64-bit arithmetic, truncating division, remainder follows dividend.
   function automatic exp_t model(input bit sg, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      exp_t   e;
      longint xa, xb, qq, rr;
      e.cyc = 0;
      if (b == '0) begin
         e.q = '0; e.r = '0; e.dbz = 1'b1;
      end else begin
         if (sg) begin
            xa = longint'($signed(a));
            xb = longint'($signed(b));
         end else begin
            xa = longint'({32'd0, a});
            xb = longint'({32'd0, b});
         end
         qq = xa / xb;
         rr = xa % xb;
         e.q = qq[WIDTH-1:0];
         e.r = rr[WIDTH-1:0];
         e.dbz = 1'b0;
      end
      return e;
   endfunction

   // Monitor: compare every done pulse against the scoreboard head.
   always @(negedge clock) begin
      exp_t e;
      if (clear_n && done) begin
         if (sb.size() == 0) begin
            check_val("unexpected_done", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            ops++;
            $display("op %0d: q=%h r=%h dbz=%b (exp q=%h r=%h dbz=%b) cyc=%0d",
                     ops, quotient, remainder, div_by_zero, e.q, e.r, e.dbz, cyc);
            check_val("quotient", quotient, e.q);
            check_val("remainder", remainder, e.r);
            check_val("div_by_zero", div_by_zero, e.dbz);
            check_val("latency", cyc, e.cyc);
         end
      end
   end

   // Called just after a rising edge; returns just after the edge where busy is low.
   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin
         @(posedge clock); #1;
         n++;
      end
      check_val("idle_timeout", busy, 0);
   endtask

   task automatic do_op(input bit sg, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input bit hold);
      exp_t e;
      wait_idle();
      signed_op = sg;
      a_in = a;
      b_in = b;
      start = 1'b1;
      @(posedge clock); #1;
      e = model(sg, a, b);
      e.cyc = cyc + ((b == '0) ? 0 : WIDTH + 1);
      sb.push_back(e);
      check_val("busy_after_start", busy, 1);
      check_val("dbz_on_start", div_by_zero, (b == '0));
      if (!hold) start = 1'b0;
   endtask

   logic [WIDTH-1:0] corner_a [5] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h7FFF_FFFF};
   logic [WIDTH-1:0] corner_b [6] = '{32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h2, 32'h0, 32'h7FFF_FFFF};

   initial begin
      logic [WIDTH-1:0] ra, rb;
      int n;

      // Power-up reset values.
      #12;
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      check_val("rst_dbz", div_by_zero, 0);
      check_val("rst_q", quotient, 0);
      check_val("rst_r", remainder, 0);
      clear_n = 1'b1;
      @(posedge clock); #1;

      // Directed: unsigned and the four sign combinations.
      do_op(0, 32'd100, 32'd7, 0);
      do_op(1, -32'd100, 32'd7, 0);
      do_op(1, 32'd100, -32'd7, 0);
      do_op(1, -32'd100, -32'd7, 0);

      // Divide by zero: flag held until the next accepted start.
      do_op(0, 32'd5, 32'd0, 0);
      wait_idle();
      repeat (3) @(posedge clock); #1;
      check_val("dbz_hold", div_by_zero, 1);
      check_val("dbz_q_hold", quotient, 0);
      do_op(0, 32'd100, 32'd7, 0);

      // Corners.
      do_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      do_op(0, 32'hFFFF_FFFF, 32'd1, 0);
      do_op(0, 32'd3, 32'd10, 0);

      // start re-pulsed mid-operation with different operands is ignored.
      do_op(0, 32'd1000, 32'd9, 0);
      repeat (9) @(posedge clock); #1;
      signed_op = 1'b1; a_in = 32'd5; b_in = 32'd0; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      wait_idle();
      check_val("result_hold", quotient, 32'd111);

      // Reset mid-operation: outputs clear immediately and no done follows.
      do_op(1, -32'd1000, 32'd3, 0);
      repeat (18) @(posedge clock);
      #2 clear_n = 1'b0;
      #1;
      check_val("abort_busy", busy, 0);
      check_val("abort_done", done, 0);
      check_val("abort_dbz", div_by_zero, 0);
      check_val("abort_q", quotient, 0);
      check_val("abort_r", remainder, 0);
      sb.delete();
      repeat (2) @(posedge clock);
      #3 clear_n = 1'b1;
      @(posedge clock); #1;
      repeat (40) @(posedge clock); #1;
      check_val("post_abort_idle", busy, 0);
      do_op(0, 32'd3, 32'd10, 0);

      // start held high: back-to-back launches after each DONE.
      for (int i = 0; i < 4; i++) begin
         do_op(i[0], 32'd1000 + 32'(i * 77), 32'd13 - 32'(i), 1);
      end
      start = 1'b0;

      // Constrained-random operands, occasionally holding start between ops.
      for (int i = 0; i < 300; i++) begin
         n = $urandom_range(0, 3);
         case (n)
            0: begin ra = $urandom; rb = $urandom; end
            1: begin ra = $urandom; rb = 32'($urandom_range(1, 15)); end
            2: begin
               ra = corner_a[$urandom_range(0, 4)];
               rb = corner_b[$urandom_range(0, 5)];
            end
            default: begin ra = 32'($urandom_range(0, 255)); rb = $urandom; end
         endcase
         if ($urandom_range(0, 1) == 1) ra = -ra;
         do_op(1'($urandom_range(0, 1)), ra, rb, ($urandom_range(0, 3) == 0));
      end
      start = 1'b0;

      // Drain the scoreboard with a bounded wait.
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clock); #1;
         n++;
      end
      check_val("drain_timeout", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
